// File: rtl/seven_seg_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_reader : decodes a debounced seven-segment image back to 3 bits
// Optional: SEVEN_SEG_CROSSCHECK_EN checks the binary digits against it.
// Revision: 1.0
// ---------------------------------------------------------------------------
module seven_seg_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] segDecimal,
   input  logic [6:0] segX2,
   input  logic [6:0] segX1,
   input  logic [6:0] segX0,
   input  logic       dataReady,
   input  logic       clrErr,
   output logic [2:0] dataValue,
   output logic       dataValid,
   output logic       dataError,
   output logic       dataMismatch,
   output logic       overrun
);

   localparam logic [6:0] BLANK      = 7'b1111111;
   localparam logic [6:0] BIN_ONE    = 7'b1111001;
   localparam logic [6:0] BIN_ZERO   = 7'b1000000;
   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      F_IDLE     = 2'd0,
      F_SETTLING = 2'd1,
      F_HELD     = 2'd2
   } filt_state_t;

   typedef enum logic [0:0] {
      O_EMPTY = 1'b0,
      O_FULL  = 1'b1
   } out_state_t;

   filt_state_t filt_state, filt_next;
   out_state_t  out_state, out_next;

   logic [27:0] sample_in;
   logic [27:0] sample_reg;
   logic [7:0]  stab_cnt;
   logic [7:0]  cnt_next;
   logic        changed;
   logic        in_blank;
   logic        accept_set;
   logic        accept_strobe;

   logic [2:0]  dec_value;
   logic        dec_error;
   logic        mismatch;

   logic        load;
   logic        overrun_evt;
   logic        go_empty;

`ifdef SEVEN_SEG_CROSSCHECK_EN
   assign sample_in = {segDecimal, segX2, segX1, segX0};
`else
   // Binary digits play no part; pin their sample fields to the blank value.
   logic unused_segx;
   assign unused_segx = ^{segX2, segX1, segX0};
   assign sample_in   = {segDecimal, BLANK, BLANK, BLANK};
`endif

   assign changed  = (sample_in != sample_reg);
   assign in_blank = (sample_in[27:21] == BLANK);

   always_comb begin
      cnt_next = stab_cnt;
      if (changed)
         cnt_next = 8'd1;
      else if (stab_cnt < STABLE_LIM)
         cnt_next = stab_cnt + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_reg    <= {4{BLANK}};
         stab_cnt      <= 8'd0;
         filt_state    <= F_IDLE;
         accept_strobe <= 1'b0;
      end else begin
         sample_reg    <= sample_in;
         stab_cnt      <= cnt_next;
         filt_state    <= filt_next;
         accept_strobe <= accept_set;
      end
   end

   always_comb begin
      filt_next  = filt_state;
      accept_set = 1'b0;
      case (filt_state)
         F_IDLE: begin
            if (!in_blank)
               filt_next = F_SETTLING;
         end
         F_SETTLING: begin
            if (changed) begin
               filt_next = in_blank ? F_IDLE : F_SETTLING;
            end else if (cnt_next == STABLE_LIM) begin
               accept_set = 1'b1;
               filt_next  = F_HELD;
            end
         end
         F_HELD: begin
            if (changed)
               filt_next = in_blank ? F_IDLE : F_SETTLING;
         end
         default: filt_next = F_IDLE;
      endcase
   end

   // The accept strobe trails the final stable sample by one edge, so the
   // registered sample still holds exactly the accepted pattern here.
   always_comb begin
      dec_value = 3'd0;
      dec_error = 1'b0;
      case (sample_reg[27:21])
         7'b1000000: dec_value = 3'd0;
         7'b1111001: dec_value = 3'd1;
         7'b0100100: dec_value = 3'd2;
         7'b0110000: dec_value = 3'd3;
         7'b0011001: dec_value = 3'd4;
         7'b0010010: dec_value = 3'd5;
         7'b0000010: dec_value = 3'd6;
         7'b1111000: dec_value = 3'd7;
         default:    dec_error = 1'b1;
      endcase
   end

`ifdef SEVEN_SEG_CROSSCHECK_EN
   logic [2:0] bin_valid;
   logic [2:0] bin_value;

   always_comb begin
      bin_valid = 3'b000;
      bin_value = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (sample_reg[i*7 +: 7] == BIN_ONE) begin
            bin_valid[i] = 1'b1;
            bin_value[i] = 1'b1;
         end else if (sample_reg[i*7 +: 7] == BIN_ZERO) begin
            bin_valid[i] = 1'b1;
         end
      end
      mismatch = (bin_valid != 3'b111) || (bin_value != dec_value);
   end
`else
   assign mismatch = 1'b0;
`endif

   always_comb begin
      out_next    = out_state;
      load        = 1'b0;
      overrun_evt = 1'b0;
      go_empty    = 1'b0;
      case (out_state)
         O_EMPTY: begin
            if (accept_strobe) begin
               load     = 1'b1;
               out_next = O_FULL;
            end
         end
         O_FULL: begin
            if (accept_strobe) begin
               if (dataReady)
                  load = 1'b1;
               else
                  overrun_evt = 1'b1;
            end else if (dataReady) begin
               go_empty = 1'b1;
               out_next = O_EMPTY;
            end
         end
         default: out_next = O_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_state    <= O_EMPTY;
         dataValue    <= 3'd0;
         dataError    <= 1'b0;
         dataMismatch <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         out_state <= out_next;
         if (load) begin
            dataValue    <= dec_value;
            dataError    <= dec_error;
            dataMismatch <= mismatch;
         end else if (go_empty) begin
            dataValue    <= 3'd0;
            dataError    <= 1'b0;
            dataMismatch <= 1'b0;
         end
         // A drop on the same edge as a clear leaves the flag set.
         if (overrun_evt)
            overrun <= 1'b1;
         else if (clrErr)
            overrun <= 1'b0;
      end
   end

   assign dataValid = (out_state == O_FULL);

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seven_seg_reader : scoreboard bench with a run-length reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_seven_seg_reader;

   localparam int N = 4;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] ONE   = 7'b1111001;
   localparam logic [6:0] ZERO  = 7'b1000000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] segDecimal = BLANK;
   logic [6:0] segX2 = BLANK;
   logic [6:0] segX1 = BLANK;
   logic [6:0] segX0 = BLANK;
   logic       dataReady = 1'b0;
   logic       clrErr = 1'b0;
   logic [2:0] dataValue;
   logic       dataValid;
   logic       dataError;
   logic       dataMismatch;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   logic [6:0] dig [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

   seven_seg_reader #(.STABLE_CYCLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .segDecimal(segDecimal),
      .segX2(segX2), .segX1(segX1), .segX0(segX0),
      .dataReady(dataReady), .clrErr(clrErr),
      .dataValue(dataValue), .dataValid(dataValid), .dataError(dataError),
      .dataMismatch(dataMismatch), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [27:0] m_last = {4{BLANK}};
   int          m_run = 0;
   bit          m_acc_pend = 1'b0;
   logic [4:0]  m_acc_item = '0;
   bit          m_valid = 1'b0;
   bit          m_ovr = 1'b0;
   logic [4:0]  exp_q [$];

   function automatic logic [4:0] ref_item(input logic [6:0] d, input logic [6:0] x2,
                                           input logic [6:0] x1, input logic [6:0] x0);
      logic [2:0] v;
      logic       err;
      logic       mm;
      logic [6:0] xs [3];
      v   = 3'd0;
      err = 1'b1;
      for (int i = 0; i < 8; i++)
         if (dig[i] == d) begin
            v   = 3'(i);
            err = 1'b0;
         end
      mm = 1'b0;
`ifdef SEVEN_SEG_CROSSCHECK_EN
      xs[0] = x0; xs[1] = x1; xs[2] = x2;
      for (int i = 0; i < 3; i++) begin
         if (xs[i] == ONE) begin
            if (v[i] != 1'b1) mm = 1'b1;
         end else if (xs[i] == ZERO) begin
            if (v[i] != 1'b0) mm = 1'b1;
         end else begin
            mm = 1'b1;
         end
      end
`else
      xs[0] = x0; xs[1] = x1; xs[2] = x2;
      if (xs[0] == 7'h00 && xs[1] == 7'h00 && xs[2] == 7'h00) mm = 1'b0;
`endif
      return {v, err, mm};
   endfunction

   always @(posedge clk) begin
      logic [27:0] s;
      bit hs;
      bit ov_ev;
      #1;
      if (!rst_n) begin
         m_last = {4{BLANK}};
         m_run = 0;
         m_acc_pend = 1'b0;
         m_valid = 1'b0;
         m_ovr = 1'b0;
         exp_q.delete();
      end else begin
         hs = m_valid && dataReady;
         ov_ev = 1'b0;
         if (m_acc_pend) begin
            if (!m_valid || hs) begin
               m_valid = 1'b1;
               exp_q.push_back(m_acc_item);
            end else begin
               ov_ev = 1'b1;
            end
         end else if (hs) begin
            m_valid = 1'b0;
         end
         if (ov_ev) m_ovr = 1'b1;
         else if (clrErr) m_ovr = 1'b0;

`ifdef SEVEN_SEG_CROSSCHECK_EN
         s = {segDecimal, segX2, segX1, segX0};
`else
         s = {segDecimal, BLANK, BLANK, BLANK};
`endif
         if (s != m_last) m_run = 1;
         else if (m_run <= N) m_run++;
         m_last = s;
         m_acc_pend = (s[27:21] != BLANK) && (m_run == N);
         if (m_acc_pend) m_acc_item = ref_item(segDecimal, segX2, segX1, segX0);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [4:0] e;
      if (rst_n) begin
         check("valid", {31'd0, dataValid}, {31'd0, m_valid});
         check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
         if (dataValid && dataReady) begin
            if (exp_q.size() == 0) begin
               check("unexpected_xfer", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("payload", {27'd0, dataValue, dataError, dataMismatch}, {27'd0, e});
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drive(input logic [6:0] d, input logic [6:0] x2,
                        input logic [6:0] x1, input logic [6:0] x0);
      segDecimal = d; segX2 = x2; segX1 = x1; segX0 = x0;
   endtask

   task automatic drive_dig(input int v);
      drive(dig[v], v[2] ? ONE : ZERO, v[1] ? ONE : ZERO, v[0] ? ONE : ZERO);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {25'd0, dataValue, dataValid, dataError, dataMismatch, overrun}, 32'd0);
      @(posedge clk);
      #2;
      drive(BLANK, BLANK, BLANK, BLANK);
      dataReady = 1'b0;
      clrErr = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic consume();
      dataReady = 1'b1;
      step(1);
      dataReady = 1'b0;
   endtask

   initial begin
      int v;
      int hold;
      logic [6:0] d;
      logic [6:0] pick;

      step(2);
      check("reset_state",
            {25'd0, dataValue, dataValid, dataError, dataMismatch, overrun}, 32'd0);
      rst_n = 1'b1;

      // latency: valid appears after edge N+1 and nothing re-accepts
      drive(7'b0110000, ZERO, ONE, ONE);
      step(N);
      check("latency_before", {31'd0, dataValid}, 32'd0);
      step(1);
      check("latency_after", {31'd0, dataValid}, 32'd1);
      check("value_3", {29'd0, dataValue}, 32'd3);
      step(12);
      consume();
      step(2);

      // glitch at the third sample
      drive_dig(4); step(2);
      drive_dig(5); step(1);
      drive_dig(4); step(N);
      check("glitch_no_early", {31'd0, dataValid}, 32'd0);
      step(2);
      check("glitch_value", {29'd0, dataValue}, 32'd4);
      consume();

      // unrecognized pattern, then long blank
      drive(7'b0101010, BLANK, BLANK, BLANK); step(N + 3);
      check("err_flag", {31'd0, dataError}, 32'd1);
      consume();
      drive(BLANK, BLANK, BLANK, BLANK); step(20);
      check("blank_no_valid", {31'd0, dataValid}, 32'd0);

      // disagreeing binary digits
      drive(7'b0000010, ONE, ZERO, ONE); step(N + 3);
`ifdef SEVEN_SEG_CROSSCHECK_EN
      check("mismatch_on", {31'd0, dataMismatch}, 32'd1);
`else
      check("mismatch_off", {31'd0, dataMismatch}, 32'd0);
`endif
      consume();

      // overrun, then reload on the accept edge, then clear
      drive_dig(2); step(N + 3);
      drive_dig(7); step(N + 3);
      check("overrun_keep_value", {29'd0, dataValue}, 32'd2);
      check("overrun_set", {31'd0, overrun}, 32'd1);
      drive_dig(1); step(N);
      dataReady = 1'b1; step(1); dataReady = 1'b0;
      check("reload_value", {29'd0, dataValue}, 32'd1);
      check("reload_overrun", {31'd0, overrun}, 32'd1);
      clrErr = 1'b1; step(1); clrErr = 1'b0;
      check("overrun_cleared", {31'd0, overrun}, 32'd0);

      // reset while FULL and mid-settle
      drive_dig(6); step(2);
      do_reset();
      drive(7'b0010010, ONE, ZERO, ONE);
      step(N);
      check("post_reset_before", {31'd0, dataValid}, 32'd0);
      step(1);
      check("post_reset_value", {29'd0, dataValue}, 32'd5);
      consume();

      // randomized phase
      for (int seg = 0; seg < 300; seg++) begin
         v = $urandom_range(0, 9);
         if (v < 8) d = dig[v];
         else if (v == 8) d = BLANK;
         else d = 7'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            pick = ($urandom_range(0, 1) == 0) ? ONE : 7'($urandom);
            drive(d, pick, ZERO, ONE);
         end else if (v < 8) begin
            drive_dig(v);
         end else begin
            drive(d, ZERO, ZERO, ZERO);
         end
         hold = $urandom_range(1, 7);
         for (int c = 0; c < hold; c++) begin
            dataReady = ($urandom_range(0, 2) == 0);
            clrErr = ($urandom_range(0, 15) == 0);
            step(1);
         end
      end

      // drain
      drive(BLANK, BLANK, BLANK, BLANK);
      clrErr = 1'b0;
      dataReady = 1'b1;
      step(N + 6);
      check("queue_drained", exp_q.size(), 32'd0);
      dataReady = 1'b0;
      step(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_reader.md
# seven_seg_reader

- Recovers the 3-bit value from a seven-segment display image, performing the opposite conversion of the team's `sevenSeg` encoder.
- Sits between a display-bus tap (or an encoder under test) and a consumer, filtering glitches with a stability counter.
- Presents each accepted value once over a valid/ready handshake, with error, mismatch and overrun reporting.

## Interface
- `STABLE_CYCLES`, 4, consecutive identical samples required before a pattern is accepted; legal range 2..255.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `segDecimal`  in  7  active-low decimal digit pattern, bit 6 = g … bit 0 = a.
- `segX2`, `segX1`, `segX0`  in  7 each  active-low binary-digit patterns, MSB to LSB.
- `dataReady`  in  1  consumer accepts `dataValue` on an edge where `dataValid` && `dataReady`.
- `clrErr`  in  1  synchronous clear of `overrun`.
- `dataValue`  out  3  decoded value.
- `dataValid`  out  1  a decoded value is pending.
- `dataError`  out  1  qualifies the pending value: decimal pattern unrecognized; `dataValue` = 0.
- `dataMismatch`  out  1  qualifies the pending value: binary digits disagree with the decimal digit.
- `overrun`  out  1  sticky: an accepted value was dropped.

## Operation

**Decode table (`segDecimal`)**
- 1000000 → 0
- 1111001 → 1
- 0100100 → 2
- 0110000 → 3
- 0011001 → 4
- 0010010 → 5
- 0000010 → 6
- 1111000 → 7
- 1111111 (blank) → never accepted; not an error.
- Any other pattern → `dataError` = 1.

**Binary digit decode**
- 1111001 → 1, 1000000 → 0, anything else → invalid.
- Invalid binary digits force `dataMismatch` = 1.

**Sampling and stability**
- The inputs are concatenated into a 28-bit sample and registered every edge.
- `stabCnt` (8 bits) resets to 1 when the sample differs from the previous sample.
- Otherwise `stabCnt` increments, saturating at `STABLE_CYCLES`.

**Filter FSM**
- IDLE: sample is blank → stay. Non-blank → SETTLING.
- SETTLING: sample changes → restart the count, staying in SETTLING if non-blank, else IDLE.
  - `stabCnt` reaches `STABLE_CYCLES` → raise the accept strobe for one cycle → HELD.
- HELD: any sample change → SETTLING (or IDLE if blank). Identical samples never re-accept.

**Output FSM**
- EMPTY → FULL on accept; loads value, error and mismatch.
- FULL → EMPTY on `dataReady`.
- FULL with accept and `dataReady` on the same edge → reload, stay FULL.
- FULL with accept and no `dataReady` → keep the old value, set `overrun`.

**Flag priority**
- `clrErr` and an overrun event on the same edge → `overrun` = 1 (set wins).

## Timing

**Reset**
- Every output = 0, both FSMs at IDLE/EMPTY, `stabCnt` = 0, sample register = 1111111 on all four fields.
- Reset asserted mid-settle or mid-handshake discards all pending state immediately (asynchronous).

**Latency**
- Input held constant before edge 1: samples taken at edges 1..N (N = `STABLE_CYCLES`).
- Accept strobe is internal at edge N; `dataValid` is visible after edge N+1.

**Handshake**
- `dataValid` stays high and its payload stays constant until the edge where `dataReady` = 1.
- `dataValid` falls on that edge unless a simultaneous accept reloads it.

**Glitch rule**
- A one-cycle change restarts the count; the new pattern needs a fresh N samples.

## Configuration
- `SEVEN_SEG_CROSSCHECK_EN` defined: the three binary digits are decoded and compared with the decimal value.
  - `dataMismatch` = 1 if any digit is invalid or disagrees.
  - `segX*` are part of the stability sample.
- Undefined: `segX*` are ignored and excluded from the stability sample; `dataMismatch` is tied to 0.

## Test plan
1. Reset, then `segDecimal` = 0110000 and binary digits 0,1,1 held, `dataReady` = 0 → `dataValid` = 1 after edge 5 (N = 4), `dataValue` = 3, flags 0; held indefinitely with no second accept.
2. Pattern 0011001 with a one-cycle glitch to 0010010 at the 3rd sample → no accept until 4 clean samples after the glitch; `dataValue` = 4.
3. `segDecimal` = 0101010 held → `dataValid` = 1, `dataError` = 1, `dataValue` = 0; blank 1111111 held 20 cycles → `dataValid` stays 0.
4. With `SEVEN_SEG_CROSSCHECK_EN`: decimal 0000010 with binary digits 1,0,1 → `dataValue` = 6, `dataMismatch` = 1. Without the macro, the same stimulus → `dataMismatch` = 0.
5. Accept 2, then change to 7 with `dataReady` = 0 → `dataValue` stays 2, `overrun` = 1. Repeat with `dataReady` = 1 on the accept edge → `dataValue` = 7, `overrun` unchanged; `clrErr` pulse → `overrun` = 0.
6. `rst_n` pulsed low while FULL and mid-settle → outputs 0 asynchronously; after release, a stable 5 (0010010) is accepted N+1 edges later.
